// File: rtl/demux_pack6_if.sv
// Symbol-in / word-out handshake bundle for demux_pack6.
// The flush request exists only when DEMUX_PACK_FLUSH_EN is defined.
interface demux_pack6_if #(
  parameter int W     = 2,
  parameter int SLOTS = 3
);
  logic                 en;
  logic                 in_valid;
  logic [W-1:0]         in_data;
  logic                 in_ready;
  logic [1:0]           slot;
  logic                 out_valid;
  logic [W*SLOTS-1:0]   out_data;
  logic                 out_ready;
`ifdef DEMUX_PACK_FLUSH_EN
  logic                 flush;

  modport master (
    output en, in_valid, in_data, out_ready, flush,
    input  in_ready, slot, out_valid, out_data
  );
  modport slave (
    input  en, in_valid, in_data, out_ready, flush,
    output in_ready, slot, out_valid, out_data
  );
`else
  modport master (
    output en, in_valid, in_data, out_ready,
    input  in_ready, slot, out_valid, out_data
  );
  modport slave (
    input  en, in_valid, in_data, out_ready,
    output in_ready, slot, out_valid, out_data
  );
`endif
endinterface

// File: rtl/demux_pack6.sv
// Packs a stream of W-bit symbols into W*SLOTS-bit words, slot k in bits [W*k +: W].
// Optional partial-word flush is enabled with the DEMUX_PACK_FLUSH_EN macro.
module demux_pack6 #(
  parameter int W     = 2,
  parameter int SLOTS = 3
) (
  input  logic           clk,
  input  logic           rst,
  demux_pack6_if.slave   bus
);
  localparam int         WORD_W = W * SLOTS;
  localparam int         ASM_W  = W * (SLOTS - 1);
  localparam logic [1:0] LAST   = 2'(SLOTS - 1);

  logic [1:0]        slot_p0;
  logic [ASM_W-1:0]  asm_p0;
  logic [WORD_W-1:0] word_p1;
  logic              vld_p1;

  logic              last;
  logic              drain_ok;
  logic              rdy;
  logic              acc;
  logic              complete;
  logic              flush_ok;
  logic              emit;
  logic [ASM_W-1:0]  asm_ins;
  logic [WORD_W-1:0] word_nxt;

  always_comb begin
    last     = (slot_p0 == LAST);
    drain_ok = !vld_p1 || bus.out_ready;
    // Non-final slots never wait on the output; only the completing symbol does.
    rdy      = bus.en && (!last || drain_ok);
    acc      = bus.in_valid && rdy;
    complete = acc && last;

    asm_ins = asm_p0;
    for (int k = 0; k < SLOTS - 1; k++) begin
      if (acc && (slot_p0 == 2'(k))) asm_ins[W*k +: W] = bus.in_data;
    end

`ifdef DEMUX_PACK_FLUSH_EN
    flush_ok = bus.flush && drain_ok && !complete && ((slot_p0 != 2'd0) || acc);
`else
    flush_ok = 1'b0;
`endif
    emit = complete || flush_ok;

    // Unfilled slots of a flushed word are already zero in the assembly register.
    word_nxt = complete ? {bus.in_data, asm_p0} : {{W{1'b0}}, asm_ins};
  end

  // Stage p0: slot counter and assembly register; stage p1: output word register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_p0 <= 2'd0;
      asm_p0  <= '0;
      word_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (emit) begin
        slot_p0 <= 2'd0;
        asm_p0  <= '0;
      end else if (acc) begin
        slot_p0 <= slot_p0 + 2'd1;
        asm_p0  <= asm_ins;
      end

      if (emit) begin
        word_p1 <= word_nxt;
        vld_p1  <= 1'b1;
      end else if (vld_p1 && bus.out_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.slot      = slot_p0;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = word_p1;

endmodule

// File: tb/tb_demux_pack6.sv
// Directed testbench for demux_pack6; flush scenario runs when DEMUX_PACK_FLUSH_EN is defined.
module tb_demux_pack6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  demux_pack6_if #(.W(2), .SLOTS(3)) bus ();

  demux_pack6 #(.W(2), .SLOTS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.slot !== 2'd0) begin failures++; $display("FAIL reset_slot got=%0d exp=0", bus.slot); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 6'b000000) begin failures++; $display("FAIL reset_out_data got=%b exp=000000", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_en0 got=%b exp=0", bus.in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [1:0] sym [3];
    sym[0] = 2'b01; sym[1] = 2'b11; sym[2] = 2'b00;
    bus.en = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = sym[i];
      #1;
      checks++; if (bus.slot !== 2'(i)) begin failures++; $display("FAIL basic_slot%0d got=%0d exp=%0d", i, bus.slot, i); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready%0d got=%b exp=1", i, bus.in_ready); end
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 6'b001101) begin failures++; $display("FAIL basic_out_data got=%b exp=001101", bus.out_data); end
    checks++; if (bus.slot !== 2'd0) begin failures++; $display("FAIL basic_slot_wrap got=%0d exp=0", bus.slot); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 6'b001101) begin failures++; $display("FAIL basic_data_kept got=%b exp=001101", bus.out_data); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sym [6];
    sym[0] = 2'b01; sym[1] = 2'b11; sym[2] = 2'b00;
    sym[3] = 2'b10; sym[4] = 2'b10; sym[5] = 2'b01;
    bus.en = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_data = sym[i];
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready%0d got=%b exp=1", i, bus.in_ready); end
      step();
      checks++;
      if (bus.out_valid !== ((i == 2) || (i == 5))) begin
        failures++; $display("FAIL b2b_out_valid%0d got=%b exp=%b", i, bus.out_valid, (i == 2) || (i == 5));
      end
      if (i == 2) begin
        checks++; if (bus.out_data !== 6'b001101) begin failures++; $display("FAIL b2b_word0 got=%b exp=001101", bus.out_data); end
      end
      if (i == 5) begin
        checks++; if (bus.out_data !== 6'b011010) begin failures++; $display("FAIL b2b_word1 got=%b exp=011010", bus.out_data); end
      end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [1:0] sym [3];
    sym[0] = 2'b01; sym[1] = 2'b11; sym[2] = 2'b00;
    bus.en = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = sym[i];
      if (i == 2) bus.out_ready = 1'b0;
      step();
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%b exp=1", bus.out_valid); end
    bus.in_data = 2'b10; #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept0 got=%b exp=1", bus.in_ready); end
    step();
    bus.in_data = 2'b01; #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept1 got=%b exp=1", bus.in_ready); end
    step();
    bus.in_data = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready%0d got=%b exp=0", i, bus.in_ready); end
      checks++; if (bus.slot !== 2'd2) begin failures++; $display("FAIL bp_stall_slot%0d got=%0d exp=2", i, bus.slot); end
      checks++; if (bus.out_data !== 6'b001101) begin failures++; $display("FAIL bp_stall_data%0d got=%b exp=001101", i, bus.out_data); end
      step();
    end
    bus.out_ready = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_no_gap got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 6'b110110) begin failures++; $display("FAIL bp_new_word got=%b exp=110110", bus.out_data); end
    checks++; if (bus.slot !== 2'd0) begin failures++; $display("FAIL bp_slot got=%0d exp=0", bus.slot); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_enable();
    bus.en = 1'b1; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 2'b01;
    step();
    bus.en = 1'b0; bus.in_data = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL en_ready%0d got=%b exp=0", i, bus.in_ready); end
      step();
      checks++; if (bus.slot !== 2'd1) begin failures++; $display("FAIL en_slot%0d got=%0d exp=1", i, bus.slot); end
    end
    bus.en = 1'b1; bus.in_data = 2'b11;
    step();
    bus.in_data = 2'b00;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL en_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 6'b001101) begin failures++; $display("FAIL en_word got=%b exp=001101", bus.out_data); end
    step();
  endtask

  task automatic test_async_reset();
    logic [1:0] sym [8];
    sym[0] = 2'b01; sym[1] = 2'b11; sym[2] = 2'b00; sym[3] = 2'b10; sym[4] = 2'b01;
    sym[5] = 2'b11; sym[6] = 2'b10; sym[7] = 2'b01;
    bus.en = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = sym[i];
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.slot !== 2'd2) begin failures++; $display("FAIL ar_pre_slot got=%0d exp=2", bus.slot); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid got=%b exp=1", bus.out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.slot !== 2'd0) begin failures++; $display("FAIL ar_slot got=%0d exp=0", bus.slot); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 6'b000000) begin failures++; $display("FAIL ar_data got=%b exp=000000", bus.out_data); end
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_data = sym[i];
      #1;
      checks++; if (bus.slot !== 2'(i - 5)) begin failures++; $display("FAIL ar_reslot%0d got=%0d exp=%0d", i - 5, bus.slot, i - 5); end
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ar_word_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 6'b011011) begin failures++; $display("FAIL ar_word got=%b exp=011011", bus.out_data); end
    step();
  endtask

`ifdef DEMUX_PACK_FLUSH_EN
  task automatic test_flush();
    bus.en = 1'b1; bus.out_ready = 1'b1; bus.flush = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 2'b10;
    step();
    bus.in_valid = 1'b0; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 6'b000010) begin failures++; $display("FAIL flush_data got=%b exp=000010", bus.out_data); end
    checks++; if (bus.slot !== 2'd0) begin failures++; $display("FAIL flush_slot got=%0d exp=0", bus.slot); end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_noop got=%b exp=0", bus.out_valid); end
  endtask
`endif

  initial begin
    bus.en = 1'b0; bus.in_valid = 1'b0; bus.in_data = 2'b00; bus.out_ready = 1'b0;
`ifdef DEMUX_PACK_FLUSH_EN
    bus.flush = 1'b0;
`endif
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_enable();
    test_async_reset();
`ifdef DEMUX_PACK_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
